// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Holds the FSM state encoding, mux select codes and data widths.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ROM_READ  = 3'd1,
        ST_RAM_READ  = 3'd2,
        ST_RAM_WRITE = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    localparam logic EMUX_ROM = 1'b0;
    localparam logic EMUX_RAM = 1'b1;

    localparam int INSTR_WIDTH = 17;
    localparam int DATA_WIDTH  = 16;

    // Wide enough for latencies up to 15 cycles.
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester/memory-side bundle of the memory access controller.
// master: requesters and memory mux side; slave: the controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    import mem_access_ctrl_pkg::*;

    logic                   fetch_req;
    logic [ADDR_WIDTH-1:0]  fetch_addr;
    logic                   data_req;
    logic                   data_we;
    logic [ADDR_WIDTH-1:0]  data_addr;
    logic [DATA_WIDTH-1:0]  data_wdata;
    logic [INSTR_WIDTH-1:0] emux_out;

    logic                   emux_select;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]  ram_wdata;
    logic                   ram_we;
    logic [INSTR_WIDTH-1:0] rdata;
    logic                   fetch_done;
    logic                   data_done;
    logic                   busy;

    modport master (
        output fetch_req, fetch_addr, data_req, data_we,
        output data_addr, data_wdata, emux_out,
        input  emux_select, rom_addr, ram_addr, ram_wdata,
        input  ram_we, rdata, fetch_done, data_done, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, data_req, data_we,
        input  data_addr, data_wdata, emux_out,
        output emux_select, rom_addr, ram_addr, ram_wdata,
        output ram_we, rdata, fetch_done, data_done, busy
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable up-counter with terminal compare for memory wait states.
// Ports: clk_i, rst_i, clr_i (to zero), en_i (count), term_i, hit_o.
module mem_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             hit_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences ROM fetches and RAM loads/stores; data beats fetch.
// Ports: clock, reset, bus (slave side of mem_access_ctrl_if).
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int ROM_LATENCY = 1,
    parameter int RAM_LATENCY = 2
) (
    input logic              clock,
    input logic              reset,
    mem_access_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] ROM_TERM =
        CNT_WIDTH'(ROM_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] RAM_TERM =
        CNT_WIDTH'(RAM_LATENCY - 1);

    state_t                 state_q;
    logic                   emux_sel_q;
    logic [ADDR_WIDTH-1:0]  rom_addr_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic [DATA_WIDTH-1:0]  ram_wdata_q;
    logic                   ram_we_q;
    logic [INSTR_WIDTH-1:0] rdata_q;
    logic                   fetch_done_q;
    logic                   data_done_q;
    logic                   busy_q;

    logic [CNT_WIDTH-1:0]   term_d;
    logic                   cnt_clr;
    logic                   cnt_en;
    logic                   cnt_hit;

    always_comb begin
        term_d  = RAM_TERM;
        if (state_q == ST_ROM_READ) begin
            term_d = ROM_TERM;
        end
        // Held at zero while idle so every read starts from 0.
        cnt_clr = (state_q == ST_IDLE);
        cnt_en  = (state_q == ST_ROM_READ) ||
                  (state_q == ST_RAM_READ);
    end

    mem_wait_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_wait (
        .clk_i  (clock),
        .rst_i  (reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (term_d),
        .hit_o  (cnt_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            emux_sel_q   <= EMUX_ROM;
            rom_addr_q   <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            rdata_q      <= '0;
            fetch_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Data side wins; a pending fetch waits.
                    if (bus.data_req) begin
                        ram_addr_q  <= bus.data_addr;
                        ram_wdata_q <= bus.data_wdata;
                        emux_sel_q  <= EMUX_RAM;
                        busy_q      <= 1'b1;
                        if (bus.data_we) begin
                            ram_we_q <= 1'b1;
                            state_q  <= ST_RAM_WRITE;
                        end else begin
                            state_q  <= ST_RAM_READ;
                        end
                    end else if (bus.fetch_req) begin
                        rom_addr_q <= bus.fetch_addr;
                        emux_sel_q <= EMUX_ROM;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ROM_READ;
                    end
                end
                ST_ROM_READ: begin
                    if (cnt_hit) begin
                        rdata_q      <= bus.emux_out;
                        fetch_done_q <= 1'b1;
                        state_q      <= ST_RESPOND;
                    end
                end
                ST_RAM_READ: begin
                    if (cnt_hit) begin
                        rdata_q     <= bus.emux_out;
                        data_done_q <= 1'b1;
                        state_q     <= ST_RESPOND;
                    end
                end
                ST_RAM_WRITE: begin
                    ram_we_q    <= 1'b0;
                    data_done_q <= 1'b1;
                    state_q     <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    fetch_done_q <= 1'b0;
                    data_done_q  <= 1'b0;
                    emux_sel_q   <= EMUX_ROM;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.emux_select = emux_sel_q;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.rdata       = rdata_q;
    assign bus.fetch_done  = fetch_done_q;
    assign bus.data_done   = data_done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (ROM_LATENCY=1, RAM_LATENCY=2).
// Drives the master side of the interface and checks each step.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_access_ctrl_if #(.ADDR_WIDTH(16)) bus ();

    mem_access_ctrl #(
        .ADDR_WIDTH  (16),
        .ROM_LATENCY (1),
        .RAM_LATENCY (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.emux_out   = '0;
        step();
        step();

        // Reset state
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_emux", 32'(bus.emux_select), 32'h0);
        chk("rst_rdata", 32'(bus.rdata), 32'h0);
        chk("rst_fdone", 32'(bus.fetch_done), 32'h0);
        chk("rst_ddone", 32'(bus.data_done), 32'h0);
        chk("rst_we", 32'(bus.ram_we), 32'h0);
        chk("rst_romaddr", 32'(bus.rom_addr), 32'h0);
        rst = 1'b0;
        step();

        // Fetch, ROM latency 1
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h0010;
        bus.emux_out   = 17'h1ABCD;
        step();
        chk("f_emux", 32'(bus.emux_select), 32'h0);
        chk("f_romaddr", 32'(bus.rom_addr), 32'h0010);
        chk("f_busy", 32'(bus.busy), 32'h1);
        chk("f_done0", 32'(bus.fetch_done), 32'h0);
        step();
        chk("f_done1", 32'(bus.fetch_done), 32'h1);
        chk("f_ddone", 32'(bus.data_done), 32'h0);
        chk("f_rdata", 32'(bus.rdata), 32'h1ABCD);
        bus.fetch_req = 1'b0;
        step();
        chk("f_done2", 32'(bus.fetch_done), 32'h0);
        chk("f_idle", 32'(bus.busy), 32'h0);

        // Fetch dropped mid ROM_READ
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h0030;
        bus.emux_out   = 17'h0A5A5;
        step();
        chk("drop_busy", 32'(bus.busy), 32'h1);
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 16'h0FFF;
        step();
        chk("drop_done", 32'(bus.fetch_done), 32'h1);
        chk("drop_rdata", 32'(bus.rdata), 32'h0A5A5);
        chk("drop_addr", 32'(bus.rom_addr), 32'h0030);
        step();
        chk("drop_done0", 32'(bus.fetch_done), 32'h0);
        chk("drop_idle", 32'(bus.busy), 32'h0);

        // RAM read, latency 2
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 16'h0100;
        bus.emux_out  = 17'h01234;
        step();
        chk("r_emux1", 32'(bus.emux_select), 32'h1);
        chk("r_addr", 32'(bus.ram_addr), 32'h0100);
        chk("r_done1", 32'(bus.data_done), 32'h0);
        chk("r_we", 32'(bus.ram_we), 32'h0);
        step();
        chk("r_emux2", 32'(bus.emux_select), 32'h1);
        chk("r_done2", 32'(bus.data_done), 32'h0);
        step();
        chk("r_emux3", 32'(bus.emux_select), 32'h1);
        chk("r_done3", 32'(bus.data_done), 32'h1);
        chk("r_fdone", 32'(bus.fetch_done), 32'h0);
        chk("r_rdata", 32'(bus.rdata), 32'h01234);
        chk("r_bit16", 32'(bus.rdata[16]), 32'h0);
        bus.data_req = 1'b0;
        step();
        chk("r_emux4", 32'(bus.emux_select), 32'h0);
        chk("r_done4", 32'(bus.data_done), 32'h0);
        chk("r_idle", 32'(bus.busy), 32'h0);

        // RAM write
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_addr  = 16'h0020;
        bus.data_wdata = 16'hBEEF;
        bus.emux_out   = 17'h15555;
        step();
        chk("w_we1", 32'(bus.ram_we), 32'h1);
        chk("w_addr", 32'(bus.ram_addr), 32'h0020);
        chk("w_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        chk("w_emux", 32'(bus.emux_select), 32'h1);
        chk("w_done1", 32'(bus.data_done), 32'h0);
        bus.data_req = 1'b0;
        bus.data_we  = 1'b0;
        step();
        chk("w_we2", 32'(bus.ram_we), 32'h0);
        chk("w_done2", 32'(bus.data_done), 32'h1);
        chk("w_rdata", 32'(bus.rdata), 32'h01234);
        step();
        chk("w_done3", 32'(bus.data_done), 32'h0);
        chk("w_idle", 32'(bus.busy), 32'h0);

        // Simultaneous requests: data first, then fetch
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h0040;
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b0;
        bus.data_addr  = 16'h0200;
        bus.emux_out   = 17'h00777;
        step();
        chk("s_emux", 32'(bus.emux_select), 32'h1);
        chk("s_romaddr", 32'(bus.rom_addr), 32'h0030);
        chk("s_ramaddr", 32'(bus.ram_addr), 32'h0200);
        step();
        chk("s_fd1", 32'(bus.fetch_done), 32'h0);
        step();
        chk("s_dd", 32'(bus.data_done), 32'h1);
        chk("s_fd2", 32'(bus.fetch_done), 32'h0);
        chk("s_rdata1", 32'(bus.rdata), 32'h00777);
        bus.data_req = 1'b0;
        bus.emux_out = 17'h1F00F;
        step();
        chk("s_idle", 32'(bus.busy), 32'h0);
        chk("s_dd0", 32'(bus.data_done), 32'h0);
        chk("s_fd3", 32'(bus.fetch_done), 32'h0);
        step();
        chk("s_fbusy", 32'(bus.busy), 32'h1);
        chk("s_romaddr2", 32'(bus.rom_addr), 32'h0040);
        chk("s_femux", 32'(bus.emux_select), 32'h0);
        step();
        chk("s_fd4", 32'(bus.fetch_done), 32'h1);
        chk("s_dd1", 32'(bus.data_done), 32'h0);
        chk("s_rdata2", 32'(bus.rdata), 32'h1F00F);
        bus.fetch_req = 1'b0;
        step();
        chk("s_end", 32'(bus.busy), 32'h0);

        // Reset in the middle of a RAM read
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 16'h0300;
        bus.emux_out  = 17'h00999;
        step();
        chk("x_emux0", 32'(bus.emux_select), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("x_emux", 32'(bus.emux_select), 32'h0);
        chk("x_busy", 32'(bus.busy), 32'h0);
        chk("x_dd", 32'(bus.data_done), 32'h0);
        chk("x_fd", 32'(bus.fetch_done), 32'h0);
        chk("x_addr", 32'(bus.ram_addr), 32'h0);
        bus.data_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("x_nodone1", 32'(bus.data_done), 32'h0);
        step();
        chk("x_nodone2", 32'(bus.data_done), 32'h0);
        chk("x_idle", 32'(bus.busy), 32'h0);

        // Fresh fetch after reset
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 16'h0050;
        bus.emux_out   = 17'h10001;
        step();
        chk("n_romaddr", 32'(bus.rom_addr), 32'h0050);
        step();
        chk("n_done", 32'(bus.fetch_done), 32'h1);
        chk("n_rdata", 32'(bus.rdata), 32'h10001);
        bus.fetch_req = 1'b0;
        step();
        chk("n_idle", 32'(bus.busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every memory access of the multicycle processor and arbitrates between two requesters: the instruction-fetch stage (ROM) and the load/store stage (RAM).
- Drives the ROM/RAM address and write strobes and the external output mux select (emux_select).
- Waits a parameterised number of cycles for each memory, captures the 17-bit mux output, then returns it with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 16, width of ROM and RAM addresses.
- ROM_LATENCY, 1, cycles from ROM address valid to ROM data valid at the mux output (legal range 1..15).
- RAM_LATENCY, 2, cycles from RAM address valid to RAM read data valid at the mux output (legal range 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  instruction fetch request; held high until fetch_done.
- fetch_addr  in  ADDR_WIDTH  ROM address.
- data_req  in  1  data access request; held high until data_done.
- data_we  in  1  1 = RAM write, 0 = RAM read; sampled with data_req.
- data_addr  in  ADDR_WIDTH  RAM address.
- data_wdata  in  16  RAM write data.
- emux_out  in  17  output of the external ROM/RAM mux.
- emux_select  out  1  0 = ROM port, 1 = RAM port.
- rom_addr  out  ADDR_WIDTH  registered ROM address.
- ram_addr  out  ADDR_WIDTH  registered RAM address.
- ram_wdata  out  16  registered RAM write data.
- ram_we  out  1  RAM write strobe.
- rdata  out  17  captured read data.
- fetch_done  out  1  one-cycle pulse; rdata holds the instruction.
- data_done  out  1  one-cycle pulse; rdata holds the load data (read), or the write has completed.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state = IDLE; every output = 0; wait counter = 0.
- States:
  - IDLE -> ROM_READ when fetch_req is high and data_req is low.
  - IDLE -> RAM_READ when data_req is high and data_we is low.
  - IDLE -> RAM_WRITE when data_req is high and data_we is high.
  - ROM_READ or RAM_READ -> RESPOND when the wait counter reaches the latency.
  - RAM_WRITE -> RESPOND after exactly 1 cycle.
  - RESPOND -> IDLE unconditionally.
- Arbitration: data_req has priority over fetch_req when both are high in IDLE. The losing fetch stays pending and is granted at the next IDLE.
- Request acceptance: requests are sampled only in IDLE. On acceptance, the address, wdata and we are latched into rom_addr, or into ram_addr/ram_wdata, on the same edge.
- Request hold: dropping a request or changing its address mid-transaction has no effect. The transaction completes and done still pulses.
- emux_select:
  - 1 in RAM_READ, RAM_WRITE, and in RESPOND when that RESPOND follows a RAM access.
  - 0 otherwise, including IDLE.
- ram_we: high only during the single RAM_WRITE cycle.
- Wait counter:
  - Cleared on entry to a read state; increments each cycle in that state.
  - On the cycle it equals LATENCY-1, emux_out is captured into rdata and the state advances to RESPOND.
  - A read therefore spends exactly LATENCY cycles in its read state.
- Response:
  - RESPOND lasts 1 cycle; fetch_done or data_done pulses high for exactly that cycle.
  - rdata stays stable from RESPOND until the next capture. Writes do not change rdata.
- Read data format: RAM reads deliver emux_out as-is. The mux zero-extends RAM data, so bit 16 reads 0.
- Latency and throughput:
  - Read: request high in IDLE at edge N -> done high in cycle N+LATENCY+1.
  - Write: done high in cycle N+2.
  - Next acceptance is possible in the cycle after RESPOND; no back-to-back overlap.
- Reset during an operation: aborts immediately to IDLE with all outputs 0. No done pulse is produced; the requester must re-issue.
- busy is 0 only in IDLE.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ROM_READ, RAM_READ, RAM_WRITE, RESPOND);
  - EMUX_ROM = 1'b0 and EMUX_RAM = 1'b1;
  - INSTR_WIDTH = 17 and DATA_WIDTH = 16.
- One natural sub-module: mem_wait_counter, a loadable up-counter with a terminal-compare output, parameterised by count width.
- The FSM, arbitration and output registers stay in mem_access_ctrl.

Test Plan:
- Fetch, ROM_LATENCY=1: fetch_req=1, fetch_addr=0x0010, emux_out=0x1ABCD -> emux_select=0 and rom_addr=0x0010 from the cycle after acceptance; fetch_done pulses 2 cycles after acceptance; rdata=0x1ABCD.
- RAM read, RAM_LATENCY=2: data_req=1, data_we=0, data_addr=0x0100, emux_out=0x01234 -> emux_select=1 for 3 cycles; data_done pulses 3 cycles after acceptance; rdata=0x01234; rdata[16]=0.
- RAM write: data_req=1, data_we=1, data_addr=0x0020, data_wdata=0xBEEF -> ram_we=1 for exactly 1 cycle with ram_addr=0x0020 and ram_wdata=0xBEEF; data_done the next cycle; rdata unchanged.
- Simultaneous requests: fetch_req=1 and data_req=1 (read) in the same IDLE cycle -> the RAM read completes first; the fetch is accepted in the IDLE after RESPOND; the done pulses appear in the order data_done, then fetch_done, never both in one cycle.
- Reset mid-read: reset asserted during the RAM_READ wait cycle -> emux_select, busy and both done outputs = 0 asynchronously; no done pulse after release; a new fetch is accepted normally.
- Requester drops fetch_req during ROM_READ -> fetch_done still pulses once; controller returns to IDLE with busy=0.
